// File: rtl/switch_box_cfg.sv
`timescale 1ns/1ps
// switch_box_cfg
// Unidirectional mux-based FPGA switch box with TRACKS tracks on each of the
// four sides (N=0, E=1, S=2, W=3). Each (track, side) output has a 2-bit
// select: 0 = off, 1/2/3 = the other three sides in clockwise order.
//
// The routing configuration lives in an active register. A new configuration
// is shifted serially, MSB-first, into a shadow register through a
// ready/valid handshake. It is then committed atomically in a single COMMIT
// cycle, so the routing stays live and glitch-free while a load is in flight.
//
// Optional build macro SWITCH_BOX_REG_OUT_EN:
//   defined   - every *_out / *_oe is registered (1-cycle input-to-output
//               latency; a commit becomes visible 2 cycles after COMMIT).
//   undefined - purely combinational routing path (0-cycle latency).

module switch_box_cfg #(
  parameter  int TRACKS   = 4,
  // Derived from TRACKS; declared local so it cannot be overridden.
  localparam int CFG_BITS = 8 * TRACKS
) (
  input  logic              clk,
  input  logic              rst_n,
  // Serial configuration loader
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic              cfg_valid,
  input  logic              cfg_data,
  output logic              cfg_ready,
  output logic              cfg_done,
  output logic              cfg_so,
  // Side inputs
  input  logic [TRACKS-1:0] n_in,
  input  logic [TRACKS-1:0] e_in,
  input  logic [TRACKS-1:0] s_in,
  input  logic [TRACKS-1:0] w_in,
  // Side outputs
  output logic [TRACKS-1:0] n_out,
  output logic [TRACKS-1:0] e_out,
  output logic [TRACKS-1:0] s_out,
  output logic [TRACKS-1:0] w_out,
  // Per-track output enables
  output logic [TRACKS-1:0] n_oe,
  output logic [TRACKS-1:0] e_oe,
  output logic [TRACKS-1:0] s_oe,
  output logic [TRACKS-1:0] w_oe
);

  // Counter is one bit wider than needed to index CFG_BITS. The terminal
  // count leaves SHIFT, so the counter never wraps.
  localparam int CNT_W = $clog2(CFG_BITS) + 1;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CFG_BITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [CFG_BITS-1:0]  shadow, shadow_nxt;
  logic [CFG_BITS-1:0]  active;
  logic                 commit;

  // Side inputs and routed results, indexed by side (N, E, S, W).
  logic [TRACKS-1:0]    side_in   [4];
  logic [TRACKS-1:0]    route_out [4];
  logic [TRACKS-1:0]    route_oe  [4];

  // ---------------------------------------------------------------------------
  // Loader FSM
  // ---------------------------------------------------------------------------

  // Next-state, handshake outputs and shadow shift for the serial loader.
  always_comb begin
    // NOTE: every signal written here gets a default first. A path that skips
    // an assignment would otherwise infer a latch.
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shadow_nxt  = shadow;
    cfg_ready   = 1'b0;
    cfg_done    = 1'b0;
    commit      = 1'b0;

    unique case (state)
      IDLE: begin
        // Abort has priority over start, even when no load is in progress.
        if (cfg_start && !cfg_abort) begin
          state_nxt   = SHIFT;
          bit_cnt_nxt = '0;
        end
      end

      SHIFT: begin
        cfg_ready = 1'b1;
        if (cfg_abort) begin
          // Drop the load. Both shadow and active are left untouched.
          state_nxt = IDLE;
        end else if (cfg_start) begin
          // Restart the count but keep the partially shifted shadow. A bit
          // presented in this cycle is not taken.
          bit_cnt_nxt = '0;
        end else if (cfg_valid) begin
          shadow_nxt  = {shadow[CFG_BITS-2:0], cfg_data};
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
          if (bit_cnt == LAST_BIT) begin
            state_nxt = COMMIT;
          end
        end
      end

      COMMIT: begin
        // A start request during the commit cycle is deliberately ignored.
        cfg_done  = 1'b1;
        commit    = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Loader state, bit counter and shadow register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shadow  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples the values from before this clock edge.
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shadow  <= shadow_nxt;
    end
  end

  // Active configuration: changes only in the COMMIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= '0;
    end else if (commit) begin
      active <= shadow;
    end
  end

  // Scan-out for daisy-chaining several switch boxes on one loader.
  assign cfg_so = shadow[CFG_BITS-1];

  // ---------------------------------------------------------------------------
  // Routing
  // ---------------------------------------------------------------------------

  assign side_in[0] = n_in;
  assign side_in[1] = e_in;
  assign side_in[2] = s_in;
  assign side_in[3] = w_in;

  // Per-track mux. Select k on side s picks side (s + k) mod 4. This yields
  // the clockwise source order, and a track only ever connects to the same
  // track index on another side.
  always_comb begin
    logic [1:0] sel;
    logic [1:0] src;
    sel = '0;
    src = '0;
    for (int s = 0; s < 4; s++) begin
      route_out[s] = '0;
      route_oe[s]  = '0;
    end
    for (int t = 0; t < TRACKS; t++) begin
      for (int s = 0; s < 4; s++) begin
        sel = active[t*8 + s*2 +: 2];
        src = 2'(s) + sel;
        if (sel != 2'd0) begin
          route_out[s][t] = side_in[src][t];
          route_oe[s][t]  = 1'b1;
        end
      end
    end
  end

`ifdef SWITCH_BOX_REG_OUT_EN
  // Registered outputs: one cycle of latency, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_out <= '0;
      e_out <= '0;
      s_out <= '0;
      w_out <= '0;
      n_oe  <= '0;
      e_oe  <= '0;
      s_oe  <= '0;
      w_oe  <= '0;
    end else begin
      n_out <= route_out[0];
      e_out <= route_out[1];
      s_out <= route_out[2];
      w_out <= route_out[3];
      n_oe  <= route_oe[0];
      e_oe  <= route_oe[1];
      s_oe  <= route_oe[2];
      w_oe  <= route_oe[3];
    end
  end
`else
  // Combinational outputs: zero-latency routing path.
  assign n_out = route_out[0];
  assign e_out = route_out[1];
  assign s_out = route_out[2];
  assign w_out = route_out[3];
  assign n_oe  = route_oe[0];
  assign e_oe  = route_oe[1];
  assign s_oe  = route_oe[2];
  assign w_oe  = route_oe[3];
`endif

endmodule
